// File: rtl/radar_pkg.sv
// Shared types and constants for the radar UART frame parser.
package radar_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned SPEED_W = 16;
    localparam int unsigned CNT_W   = 16;

    localparam logic [BYTE_W-1:0] HDR_BYTE     = 8'hAA;
    localparam logic [BYTE_W-1:0] TRL_BYTE     = 8'h55;
    localparam logic [BYTE_W-1:0] DIR_APPROACH = 8'h00;
    localparam logic [BYTE_W-1:0] DIR_RECEDE   = 8'h01;

    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_DIR    = 3'd1,
        ST_SPD_HI = 3'd2,
        ST_SPD_LO = 3'd3,
        ST_CSUM   = 3'd4,
        ST_TRAIL  = 3'd5
    } state_t;

    typedef struct packed {
        logic [SPEED_W-1:0] speed;
        logic               dir;
        logic               overspeed;
    } radar_rec_t;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up counter that sticks at all-ones; synchronous active-low clear.
module sat_counter16
    import radar_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/radar_frame_parser.sv
// Extracts AA/DIR/SPD_HI/SPD_LO/CSUM/55 speed-radar frames from the UART byte
// stream, presents one record per good frame and counts good/bad frames.
module radar_frame_parser
    import radar_pkg::*;
#(
    parameter int unsigned SPEED_LIMIT    = 600,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_error,
    output logic        in_ready,
    output logic [15:0] out_speed,
    output logic        out_dir,
    output logic        out_overspeed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] good_frames,
    output logic [15:0] bad_frames
);

    localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_byte_ok;
    logic                w_timeout;
    logic                w_good;
    logic                w_bad;
    logic                r_dir;
    logic [BYTE_W-1:0]   r_spd_hi;
    logic [BYTE_W-1:0]   r_spd_lo;
    logic [BYTE_W-1:0]   r_sum;
    logic                r_mismatch;
    logic [IDLE_W-1:0]   r_idle;
    radar_rec_t          r_rec;
    logic                r_out_valid;
    logic [SPEED_W-1:0]  w_speed;

    // Back-pressure only while a record is held and not being taken.
    assign in_ready  = !(r_out_valid && !out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_byte_ok = w_accept && !in_error;
    assign w_timeout = (r_state != ST_HUNT) && !w_accept && (r_idle == IDLE_LAST);
    assign w_speed   = {r_spd_hi, r_spd_lo};

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus good/bad frame strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        if (r_state == ST_HUNT) begin
            if (w_byte_ok && (in_data == HDR_BYTE)) begin
                w_state_nxt = ST_DIR;
            end
        end else if (w_accept && in_error) begin
            w_bad       = 1'b1;
            w_state_nxt = ST_HUNT;
        end else if (w_accept) begin
            case (r_state)
                ST_DIR: begin
                    if ((in_data == DIR_APPROACH) || (in_data == DIR_RECEDE)) begin
                        w_state_nxt = ST_SPD_HI;
                    end else begin
                        w_bad       = 1'b1;
                        w_state_nxt = ST_HUNT;
                    end
                end
                ST_SPD_HI: w_state_nxt = ST_SPD_LO;
                ST_SPD_LO: w_state_nxt = ST_CSUM;
                ST_CSUM:   w_state_nxt = ST_TRAIL;
                ST_TRAIL: begin
                    if ((in_data == TRL_BYTE) && !r_mismatch) begin
                        w_good = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                    end
                    w_state_nxt = ST_HUNT;
                end
                default: w_state_nxt = ST_HUNT;
            endcase
        end else if (w_timeout) begin
            w_bad       = 1'b1;
            w_state_nxt = ST_HUNT;
        end
    end

    // Field capture, running checksum, idle timer and output record.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_dir       <= 1'b0;
            r_spd_hi    <= '0;
            r_spd_lo    <= '0;
            r_sum       <= '0;
            r_mismatch  <= 1'b0;
            r_idle      <= '0;
            r_rec       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept || (r_state == ST_HUNT)) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + IDLE_W'(1);
            end

            if (w_byte_ok) begin
                case (r_state)
                    ST_DIR: begin
                        r_dir <= in_data[0];
                        r_sum <= in_data;
                    end
                    ST_SPD_HI: begin
                        r_spd_hi <= in_data;
                        r_sum    <= r_sum + in_data;
                    end
                    ST_SPD_LO: begin
                        r_spd_lo <= in_data;
                        r_sum    <= r_sum + in_data;
                    end
                    ST_CSUM:  r_mismatch <= (in_data != r_sum);
                    default: ;
                endcase
            end

            if (w_good) begin
                r_rec.speed     <= w_speed;
                r_rec.dir       <= r_dir;
                r_rec.overspeed <= (w_speed > SPEED_W'(SPEED_LIMIT));
                r_out_valid     <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_speed     = r_rec.speed;
    assign out_dir       = r_rec.dir;
    assign out_overspeed = r_rec.overspeed;
    assign out_valid     = r_out_valid;

    sat_counter16 u_good_cnt (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .i_inc   (w_good),
        .o_count (good_frames)
    );

    sat_counter16 u_bad_cnt (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .i_inc   (w_bad),
        .o_count (bad_frames)
    );

endmodule

// File: tb/tb_radar_frame_parser.sv
// Scoreboard bench for radar_frame_parser: frame-level reference model feeds an
// expected-record queue; an independent monitor checks every handshake.
module tb_radar_frame_parser;
    import radar_pkg::*;

    localparam int unsigned TO    = 100;
    localparam int unsigned LIMIT = 600;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_error;
    logic        in_ready;
    logic [15:0] out_speed;
    logic        out_dir;
    logic        out_overspeed;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] good_frames;
    logic [15:0] bad_frames;

    always #5 clk = ~clk;

    radar_frame_parser #(.SPEED_LIMIT(LIMIT), .TIMEOUT_CYCLES(TO)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_error      (in_error),
        .in_ready      (in_ready),
        .out_speed     (out_speed),
        .out_dir       (out_dir),
        .out_overspeed (out_overspeed),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .good_frames   (good_frames),
        .bad_frames    (bad_frames)
    );

    typedef struct {
        int unsigned speed;
        bit          dir;
        bit          over;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          errors    = 0;
    int          checks    = 0;
    int          exp_good  = 0;
    int          exp_bad   = 0;
    int          rdy_mode  = 0;
    bit          mon_en    = 1'b0;
    bit          prev_hold = 1'b0;
    int unsigned prev_rec  = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Consumer ready: 0 = always ready, 1 = stalled, else random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: record stability while held, ready rule, and scoreboard pops.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_hold) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_record", 32'({out_speed, out_dir, out_overspeed}), prev_rec);
            end
            check("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_record: got speed 0x%0h, required none", out_speed);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rec_speed", 32'(out_speed), mon_e.speed);
                    check("rec_dir", 32'(out_dir), 32'(mon_e.dir));
                    check("rec_overspeed", 32'(out_overspeed), 32'(mon_e.over));
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_rec  = 32'({out_speed, out_dir, out_overspeed});
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit e);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_error = e;
        n = 0;
        while (!in_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) fail_now("in_ready_wait");
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        in_error = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic make_frame(input int unsigned spd, input logic [7:0] dir, output logic [7:0] b[6]);
        b[0] = 8'hAA;
        b[1] = dir;
        b[2] = 8'(spd >> 8);
        b[3] = 8'(spd);
        b[4] = 8'((int'(b[1]) + int'(b[2]) + int'(b[3])) % 256);
        b[5] = 8'h55;
    endtask

    // Frame-level rules: how many bytes the parser consumes and the verdict.
    task automatic classify(input logic [7:0] b[6], input bit e[6], output int nsent, output bit good);
        nsent = 6;
        good  = 1'b0;
        for (int k = 1; k < 6; k++) begin
            if (e[k]) begin
                nsent = k + 1;
                return;
            end
            if (k == 1 && b[1] > 8'd1) begin
                nsent = 2;
                return;
            end
        end
        good = (int'(b[4]) == (int'(b[1]) + int'(b[2]) + int'(b[3])) % 256) && (b[5] == 8'h55);
    endtask

    task automatic run_frame(input logic [7:0] b[6], input bit e[6], input bit gaps);
        int   nsent;
        bit   good;
        exp_t x;
        classify(b, e, nsent, good);
        if (good) begin
            x.speed = {24'd0, b[2]} * 256 + {24'd0, b[3]};
            x.dir   = b[1][0];
            x.over  = (x.speed > LIMIT);
            exp_q.push_back(x);
            exp_good++;
        end else begin
            exp_bad++;
        end
        for (int k = 0; k < nsent; k++) begin
            if (gaps && k > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send_byte(b[k], e[k]);
        end
    endtask

    task automatic good_frame(input int unsigned spd, input logic [7:0] dir);
        logic [7:0] b[6];
        bit         e[6];
        make_frame(spd, dir, b);
        e = '{default: 1'b0};
        run_frame(b, e, 1'b0);
    endtask

    task automatic check_counts(input string tag);
        idle(4);
        check({tag, "_good"}, 32'(good_frames), exp_good);
        check({tag, "_bad"}, 32'(bad_frames), exp_bad);
    endtask

    initial begin
        logic [7:0]  b[6];
        bit          e[6];
        int unsigned spd;
        int          k;

        in_valid = 1'b0;
        in_data  = 8'h00;
        in_error = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_speed", 32'(out_speed), 0);
        check("rst_dir", 32'(out_dir), 0);
        check("rst_over", 32'(out_overspeed), 0);
        check("rst_good", 32'(good_frames), 0);
        check("rst_bad", 32'(bad_frames), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Directed frames from the plan.
        good_frame(600, 8'h00);
        check_counts("d1");
        good_frame(601, 8'h01);
        check_counts("d2");
        b = '{8'hAA, 8'h00, 8'h01, 8'h00, 8'h02, 8'h55};
        e = '{default: 1'b0};
        run_frame(b, e, 1'b0);
        check_counts("bad_csum");
        good_frame(100, 8'h00);
        check_counts("after_bad");
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        good_frame(1234, 8'h01);
        check_counts("garbage");

        // Timeout mid-frame.
        send_byte(8'hAA, 1'b0);
        send_byte(8'h00, 1'b0);
        idle(TO + 20);
        exp_bad++;
        check_counts("timeout");
        good_frame(599, 8'h00);
        check_counts("post_timeout");

        // Held record and back-pressure, then release.
        rdy_mode = 1;
        idle(3);
        good_frame(700, 8'h01);
        idle(3);
        @(negedge clk);
        check("held_valid", 32'(out_valid), 1);
        check("held_in_ready", 32'(in_ready), 0);
        check("held_speed", 32'(out_speed), 700);
        fork
            good_frame(42, 8'h00);
            begin
                repeat (10) @(posedge clk);
                @(negedge clk);
                check("stall_good", 32'(good_frames), exp_good - 1);
                rdy_mode = 0;
            end
        join
        check_counts("release");

        // Error flag on SPD_LO drops the frame.
        make_frame(300, 8'h00, b);
        e = '{default: 1'b0};
        e[3] = 1'b1;
        run_frame(b, e, 1'b0);
        check_counts("in_error");

        // Randomized traffic.
        rdy_mode = 2;
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 3))
                0:       spd = 600;
                1:       spd = 601;
                2:       spd = 599;
                default: spd = $urandom_range(0, 65535);
            endcase
            make_frame(spd, 8'($urandom_range(0, 1)), b);
            e = '{default: 1'b0};
            case ($urandom_range(0, 7))
                0: b[1] = 8'($urandom_range(0, 255));
                1: b[4] = b[4] ^ 8'($urandom_range(1, 255));
                2: b[5] = 8'($urandom_range(0, 255));
                3: e[$urandom_range(1, 5)] = 1'b1;
                4: begin
                    for (int g = 0; g < 3; g++) begin
                        k = $urandom_range(0, 255);
                        if (k == 'hAA) send_byte(8'hAA, 1'b1);
                        else send_byte(8'(k), 1'($urandom_range(0, 1)));
                    end
                end
                5: begin
                    k = $urandom_range(1, 5);
                    for (int j = 0; j < k; j++) send_byte(b[j], 1'b0);
                    idle(TO + 10);
                    exp_bad++;
                    continue;
                end
                default: ;
            endcase
            run_frame(b, e, 1'b1);
        end
        rdy_mode = 0;
        idle(30);
        check("drain_queue", 32'(exp_q.size()), 0);
        check_counts("random");

        // Reset in the middle of a frame.
        send_byte(8'hAA, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        idle(2);
        @(negedge clk);
        mon_en    = 1'b0;
        prev_hold = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        mon_en   = 1'b1;
        exp_good = 0;
        exp_bad  = 0;
        check("midrst_valid", 32'(out_valid), 0);
        check_counts("midrst");
        good_frame(900, 8'h01);
        check_counts("post_rst");
        check("final_queue", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/radar_frame_parser.md
# radar_frame_parser

Consumes the received byte stream of the radar RS232 UART (Avalon-ST from_uart side) and extracts complete speed-radar frames. Each valid frame yields one speed/direction record with an overspeed flag on a ready/valid output. Sits between the UART receive stream and the traffic-logic/display stage. Keeps saturating good/bad frame counters for diagnostics.

## Interface
- SPEED_LIMIT, 16'd600, overspeed threshold in speed units (0.1 km/h)
- TIMEOUT_CYCLES, 50_000_000, maximum idle cycles between bytes inside a frame
- clk_clk  in  1  system clock
- reset_reset_n  in  1  synchronous, active-low reset
- in_data  in  8  byte from UART (from_uart_data)
- in_valid  in  1  byte present (from_uart_valid)
- in_error  in  1  UART framing/parity error qualifying in_data
- in_ready  out  1  parser accepts byte (drives from_uart_ready)
- out_speed  out  16  speed, 0.1 km/h units
- out_dir  out  1  0 = approaching, 1 = receding
- out_overspeed  out  1  out_speed > SPEED_LIMIT
- out_valid  out  1  record held
- out_ready  in  1  consumer accepts record
- good_frames  out  16  saturating count of accepted frames
- bad_frames  out  16  saturating count of rejected frames

## Operation
- Frame: 0xAA header, DIR, SPD_HI, SPD_LO, CSUM, 0x55 trailer. CSUM = (DIR + SPD_HI + SPD_LO) mod 256.
- Byte accepted when in_valid && in_ready. in_ready = !(out_valid && !out_ready).
- States: HUNT -> DIR -> SPD_HI -> SPD_LO -> CSUM -> TRAIL -> HUNT.
- HUNT: non-0xAA bytes discarded, no counter change; 0xAA -> DIR.
- DIR: byte 0x00/0x01 stored -> SPD_HI; any other value is a bad frame -> HUNT.
- SPD_HI, SPD_LO: stored; 8-bit running sum accumulated from DIR onward.
- CSUM: compare with running sum; mismatch latched, state -> TRAIL regardless.
- TRAIL: 0x55 and no mismatch -> good frame; else bad frame. Always -> HUNT (no resync on a 0xAA trailer).
- Accepted byte with in_error=1 in any state: byte dropped; outside HUNT, bad frame and -> HUNT.
- Timeout: idle counter cleared on every accepted byte and in HUNT; outside HUNT reaching TIMEOUT_CYCLES-1 -> bad frame, -> HUNT.
- Good frame: out_speed={SPD_HI,SPD_LO}, out_dir=DIR[0], out_overspeed computed unsigned, out_valid=1, good_frames++.
- Bad frame: bad_frames++, output register untouched.
- Counters saturate at 16'hFFFF.

## Timing
- Reset: state HUNT, in_ready=1, out_valid=0, out_speed=0, out_dir=0, out_overspeed=0, counters 0, idle counter 0.
- Trailer accepted in cycle N -> out_valid, record and good_frames update visible in cycle N+1.
- Bad-frame detection in cycle N -> bad_frames update in N+1.
- out_valid held with stable record until out_valid && out_ready; clears next cycle unless a new good frame completes in that same cycle (then reloads, stays 1).
- in_ready falls in the cycle after out_valid rises while out_ready=0; rises combinationally with out_ready.
- Byte accept and timeout in the same cycle: byte wins, counter cleared.
- Reset asserted mid-frame: partial frame discarded, no counter increment.

## Structure
- Shared package radar_pkg: state enum, HDR_BYTE=8'hAA, TRL_BYTE=8'h55, DIR_APPROACH/DIR_RECEDE codes, record struct (speed, dir, overspeed).
- One sub-module natural: sat_counter16 (increment enable, saturation), instantiated twice.

## Test plan
- Reset, then feed AA 00 02 58 5A 55 with out_ready=1 -> one cycle out_valid, out_speed=600, out_dir=0, out_overspeed=0, good_frames=1.
- Feed AA 01 02 59 5C 55 -> out_speed=601, out_dir=1, out_overspeed=1.
- Feed AA 00 01 00 02 55 (bad CSUM, expected 01) -> no out_valid, bad_frames=1; then a valid frame still parses.
- Garbage 12 34 then a valid frame -> garbage ignored, bad_frames unchanged, good_frames=1.
- Send AA 00, then idle TIMEOUT_CYCLES (use TIMEOUT_CYCLES=100) -> bad_frames=1, state HUNT; next full frame accepted.
- out_ready=0, two back-to-back valid frames -> first held stable, in_ready=0 after first completes, second byte stream stalls; raising out_ready delivers both in order, no byte lost; in_error=1 on SPD_LO byte -> bad_frames++, frame dropped.
